// File: rtl/avg_write_sequencer.sv
// Average-pool output write sequencer: steers GROUP-wide result beats onto
// consecutive lanes of the lane-buffer bank for a programmable number of sweeps.

module avg_write_lane #(
    parameter int LANE   = 0,
    parameter int GROUP  = 3,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5,
    parameter int LN_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept,
    input  logic [IDX_W-1:0]        base,
    input  logic [LN_W-1:0]         lanes,
    input  logic [GROUP*DATA_W-1:0] data,
    output logic                    sel,
    output logic [DATA_W-1:0]       wr
);
    logic             hit;
    logic [IDX_W-1:0] off;
    logic [DATA_W-1:0] val;

    always_comb begin
        off = IDX_W'(LANE) - base;
        hit = accept && (IDX_W'(LANE) >= base) && (off < IDX_W'(GROUP))
              && (IDX_W'(LANE) < IDX_W'(lanes));
        val = '0;
        for (int k = 0; k < GROUP; k++)
            if (off == IDX_W'(k)) val = data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= 1'b0;
            wr  <= '0;
        end else begin
            sel <= hit;
            wr  <= hit ? val : '0;
        end
    end
endmodule

module avg_write_sequencer #(
    parameter int NUM_LANES   = 16,
    parameter int GROUP       = 3,
    parameter int DATA_W      = 16,
    parameter int OPC_W       = 6,
    parameter int BASE_OPCODE = 32,
    parameter int PASS_W      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [$clog2(NUM_LANES+1)-1:0] i_cfgLanes,
    input  logic [PASS_W-1:0]             i_cfgPasses,
    input  logic                          i_valid,
    input  logic [GROUP*DATA_W-1:0]       i_data,
    output logic                          o_ready,
    output logic [NUM_LANES-1:0]          o_selWrite,
    output logic [NUM_LANES*DATA_W-1:0]   o_wrData,
    output logic [OPC_W-1:0]              o_opcode,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int LN_W    = $clog2(NUM_LANES+1);
    localparam int NGROUPS = (NUM_LANES + GROUP - 1) / GROUP;
    localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int IDX_W   = $clog2(NUM_LANES + GROUP + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [LN_W-1:0]   lanes_q, lanes_cl;
    logic [GRP_W-1:0]  grp, last_grp, last_grp_cl;
    logic [PASS_W-1:0] pass, passes_q, passes_cl;
    logic              accept;
    logic [IDX_W-1:0]  base;
    logic [NUM_LANES-1:0][DATA_W-1:0] wr_lane;

    // Clamp runtime config so out-of-range values fall back to a full single sweep.
    always_comb begin
        lanes_cl = i_cfgLanes;
        if (i_cfgLanes == '0 || i_cfgLanes > LN_W'(NUM_LANES))
            lanes_cl = LN_W'(NUM_LANES);
        last_grp_cl = GRP_W'((32'(lanes_cl) + 32'(GROUP) - 32'd1) / 32'(GROUP) - 32'd1);
        passes_cl   = (i_cfgPasses == '0) ? PASS_W'(1) : i_cfgPasses;
    end

    assign accept   = i_valid && o_ready;
    assign base     = IDX_W'(grp) * IDX_W'(GROUP);
    assign o_wrData = wr_lane;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            lanes_q  <= '0;
            last_grp <= '0;
            passes_q <= '0;
            grp      <= '0;
            pass     <= '0;
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_opcode <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    lanes_q  <= lanes_cl;
                    last_grp <= last_grp_cl;
                    passes_q <= passes_cl;
                    grp      <= '0;
                    pass     <= '0;
                    o_ready  <= 1'b1;
                    o_busy   <= 1'b1;
                    state    <= RUN;
                end
                RUN: if (accept) begin
                    o_opcode <= OPC_W'(BASE_OPCODE) + OPC_W'(grp);
                    if (grp == last_grp) begin
                        grp <= '0;
                        if (pass == passes_q - PASS_W'(1)) begin
                            o_ready <= 1'b0;
                            o_busy  <= 1'b0;
                            state   <= DONE;
                        end else begin
                            pass <= pass + PASS_W'(1);
                        end
                    end else begin
                        grp <= grp + GRP_W'(1);
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        avg_write_lane #(
            .LANE(l), .GROUP(GROUP), .DATA_W(DATA_W), .IDX_W(IDX_W), .LN_W(LN_W)
        ) u_lane (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .accept (accept),
            .base   (base),
            .lanes  (lanes_q),
            .data   (i_data),
            .sel    (o_selWrite[l]),
            .wr     (wr_lane[l])
        );
    end
endmodule

// File: tb/tb_avg_write_sequencer.sv
// Randomized bench for avg_write_sequencer: a beat-counting reference model
// predicts every output each cycle; literal write logs pin the model.

module tb_avg_write_sequencer;
    localparam int NL = 16, G = 3, DW = 16, OW = 6, PW = 8, BASE = 32;
    localparam int LNW = $clog2(NL+1);

    logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
    logic [LNW-1:0]  cfg_lanes = '0;
    logic [PW-1:0]   cfg_passes = '0;
    logic [G*DW-1:0] data = '0;
    logic            ready, busy, done;
    logic [NL-1:0]   sel;
    logic [NL*DW-1:0] wr;
    logic [OW-1:0]   opcode;

    avg_write_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cfgLanes(cfg_lanes),
        .i_cfgPasses(cfg_passes), .i_valid(valid), .i_data(data), .o_ready(ready),
        .o_selWrite(sel), .o_wrData(wr), .o_opcode(opcode), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    // Model: a run is just "beats accepted so far" out of ag*passes total.
    bit m_run = 0, m_arm = 0, m_done_seen = 0;
    int m_beats = 0, m_total = 0, m_lanes = 0, m_ag = 1;
    logic [NL-1:0]    e_sel = '0;
    logic [NL*DW-1:0] e_wr = '0;
    logic [OW-1:0]    e_op = '0;
    bit e_ready = 0, e_busy = 0, e_done = 0;

    logic [NL-1:0]    log_sel[$];
    logic [OW-1:0]    log_op[$];
    logic [NL*DW-1:0] log_wr[$];
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model();
        bit was_done;
        int g, lo, hi, np;
        if (!rst_n) begin
            m_run = 0; m_arm = 0; m_beats = 0;
            e_sel = '0; e_wr = '0; e_op = '0; e_ready = 0; e_busy = 0; e_done = 0;
            return;
        end
        was_done = m_arm;
        m_arm = 0;
        e_done = was_done;
        if (was_done) m_done_seen = 1;
        e_sel = '0;
        e_wr = '0;
        if (m_run) begin
            if (valid) begin
                g  = m_beats % m_ag;
                lo = g * G;
                hi = (lo + G < m_lanes) ? lo + G : m_lanes;
                for (int l = 0; l < NL; l++)
                    if (l >= lo && l < hi) begin
                        e_sel[l] = 1'b1;
                        e_wr[l*DW +: DW] = data[(l-lo)*DW +: DW];
                    end
                e_op = OW'(BASE + g);
                m_beats++;
                if (m_beats == m_total) begin
                    m_run = 0;
                    m_arm = 1;
                end
            end
        end else if (!was_done && start) begin
            m_lanes = (cfg_lanes == 0 || int'(cfg_lanes) > NL) ? NL : int'(cfg_lanes);
            m_ag    = (m_lanes + G - 1) / G;
            np      = (cfg_passes == 0) ? 1 : int'(cfg_passes);
            m_total = m_ag * np;
            m_beats = 0;
            m_run   = 1;
        end
        e_ready = m_run;
        e_busy  = m_run;
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("o_selWrite", 256'(sel), 256'(e_sel));
        chk("o_wrData", 256'(wr), 256'(e_wr));
        chk("o_opcode", 256'(opcode), 256'(e_op));
        chk("o_ready", 256'(ready), 256'(e_ready));
        chk("o_busy", 256'(busy), 256'(e_busy));
        chk("o_done", 256'(done), 256'(e_done));
        if (sel != '0) begin
            log_sel.push_back(sel);
            log_op.push_back(opcode);
            log_wr.push_back(wr);
        end
        if (done) done_cnt++;
    end

    task automatic clear_log();
        log_sel.delete(); log_op.delete(); log_wr.delete();
        done_cnt = 0;
    endtask

    // mode 0: valid every cycle, 1: valid 1,0,0 repeating, 2: random valid
    task automatic run_seq(input int lanes, input int passes, input int mode,
                           input bit fixed, input bit start_noise);
        bit got;
        cfg_lanes   = LNW'(lanes);
        cfg_passes  = PW'(passes);
        start       = 1'b1;
        valid       = 1'($urandom % 2);
        data        = 48'({$urandom(), $urandom()});
        m_done_seen = 0;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            valid = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom % 2);
            data  = fixed ? {16'd3, 16'd2, 16'd1} : 48'({$urandom(), $urandom()});
            start = start_noise ? 1'($urandom % 2) : 1'b0;
            step();
            if (m_done_seen) got = 1;
        end
        start = 1'b0;
        valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout: got no done expected done within 400 cycles");
        end
        step(); step();
    endtask

    logic [NL-1:0] mask1[6] = '{16'h0007, 16'h0038, 16'h01C0, 16'h0E00, 16'h7000, 16'h8000};
    logic [255:0] lane9_one;

    initial begin
        lane9_one = 256'd1 << (9*DW);
        step();
        chk_en = 1;
        step();
        rst_n = 1'b1;
        step();

        clear_log();
        run_seq(16, 1, 0, 0, 0);
        chk("t1 writes", 256'(log_sel.size()), 256'd6);
        for (int i = 0; i < 6 && i < log_sel.size(); i++) begin
            chk("t1 mask", 256'(log_sel[i]), 256'(mask1[i]));
            chk("t1 opcode", 256'(log_op[i]), 256'(32 + i));
        end
        chk("t1 done", 256'(done_cnt), 256'd1);

        clear_log();
        run_seq(10, 1, 0, 1, 0);
        chk("t2 writes", 256'(log_sel.size()), 256'd4);
        if (log_sel.size() == 4) begin
            chk("t2 last mask", 256'(log_sel[3]), 256'h0200);
            chk("t2 last data", 256'(log_wr[3]), lane9_one);
        end
        chk("t2 done", 256'(done_cnt), 256'd1);

        clear_log();
        run_seq(16, 2, 0, 0, 0);
        chk("t3 writes", 256'(log_sel.size()), 256'd12);
        for (int i = 0; i < 12 && i < log_op.size(); i++)
            chk("t3 opcode", 256'(log_op[i]), 256'(32 + i % 6));
        chk("t3 done", 256'(done_cnt), 256'd1);

        clear_log();
        run_seq(16, 1, 1, 0, 0);
        chk("t4 writes", 256'(log_sel.size()), 256'd6);
        for (int i = 0; i < 6 && i < log_sel.size(); i++)
            chk("t4 mask", 256'(log_sel[i]), 256'(mask1[i]));

        // Reset in the middle of a run, after three accepted beats.
        cfg_lanes = LNW'(16); cfg_passes = PW'(1); start = 1'b1;
        step();
        start = 1'b0; valid = 1'b1;
        repeat (3) step();
        valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clear_log();
        run_seq(16, 1, 0, 0, 0);
        if (log_sel.size() > 0) chk("t5 restart mask", 256'(log_sel[0]), 256'h0007);
        else chk("t5 restart writes", 256'(log_sel.size()), 256'd6);

        clear_log();
        run_seq(0, 0, 0, 0, 1);
        chk("t6 writes", 256'(log_sel.size()), 256'd6);
        chk("t6 done", 256'(done_cnt), 256'd1);

        for (int r = 0; r < 8; r++)
            run_seq(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 0, 1'($urandom % 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
